// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge: turns each accepted AHB transfer into one APB SETUP/ENABLE access.
// HADDR[15:12] picks the APB slave; indices beyond NUM_SLAVES return a two-cycle AHB ERROR.
module ahb_apb_bridge #(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 12
) (
   input  logic                  HCLK,
   input  logic                  nRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [NUM_SLAVES-1:0] PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_W-1:0]     PADDR,
   output logic [31:0]           PWDATA,
   input  logic [31:0]           PRDATA
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WDATA  = 3'd1;
   localparam logic [2:0] ST_SETUP  = 3'd2;
   localparam logic [2:0] ST_ENABLE = 3'd3;
   localparam logic [2:0] ST_RDONE  = 3'd4;
   localparam logic [2:0] ST_ERR1   = 3'd5;
   localparam logic [2:0] ST_ERR2   = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [31:0]       pwdata_q, pwdata_d;
   logic [31:0]       hrdata_q, hrdata_d;
   logic [3:0]        idx_q, idx_d;
   logic              ready_out;
   logic              accept;
   logic              addr_err;
   logic              unused_bits;

   assign unused_bits = ^{HTRANS[0], HADDR[31:16]};

   assign accept   = HSEL & HREADY & HTRANS[1];
   assign addr_err = int'(HADDR[15:12]) >= NUM_SLAVES;

   // A write's ENABLE cycle already completes the AHB data phase, so it can take the next address.
   always_comb begin
      ready_out = 1'b0;
      case (state_q)
         ST_IDLE, ST_RDONE, ST_ERR2: ready_out = 1'b1;
         ST_ENABLE:                  ready_out = pwrite_q;
         default:                    ready_out = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      idx_d    = idx_q;
      case (state_q)
         ST_WDATA: begin
            pwdata_d = HWDATA;
            state_d  = ST_SETUP;
         end
         ST_SETUP: state_d = ST_ENABLE;
         ST_ENABLE: begin
            if (!pwrite_q) begin
               hrdata_d = PRDATA;
               state_d  = ST_RDONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
      if (ready_out && accept) begin
         paddr_d  = HADDR[ADDR_W-1:0];
         pwrite_d = HWRITE;
         idx_d    = HADDR[15:12];
         if (addr_err)
            state_d = ST_ERR1;
         else if (HWRITE)
            state_d = ST_WDATA;
         else
            state_d = ST_SETUP;
      end
   end

   always_ff @(posedge HCLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         hrdata_q <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
         idx_q    <= idx_d;
      end
   end

   always_comb begin
      PSEL = '0;
      if (state_q == ST_SETUP || state_q == ST_ENABLE) begin
         for (int i = 0; i < NUM_SLAVES; i++)
            PSEL[i] = (idx_q == 4'(i));
      end
   end

   assign PENABLE   = (state_q == ST_ENABLE);
   assign HREADYOUT = ready_out;
   assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
   assign HRDATA    = hrdata_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: a latency-table model checks every cycle while directed
// and random AHB traffic runs, with literal checks pinning the documented examples.
module tb_ahb_apb_bridge;

   localparam int NS = 4;

   logic          HCLK = 1'b0;
   logic          nRESET;
   logic          HSEL;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;
   logic [NS-1:0] PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [11:0]   PADDR;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA;
   logic          hready_block;

   int checks = 0;
   int fails  = 0;

   ahb_apb_bridge #(.NUM_SLAVES(NS), .ADDR_W(12)) dut (
      .HCLK(HCLK), .nRESET(nRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
      .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
   );

   always #5 HCLK = ~HCLK;

   // The bus-wide HREADY follows the bridge unless another slave is stalling the bus.
   assign HREADY = HREADYOUT & ~hready_block;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic blk);
      @(posedge HCLK);
      #1;
      HSEL         = sel;
      HTRANS       = trans;
      HWRITE       = wr;
      HADDR        = addr;
      HWDATA       = wdata;
      PRDATA       = rdata;
      hready_block = blk;
   endtask

   task automatic idleCycle(input logic [31:0] rdata);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, rdata, 1'b0);
   endtask

   // Model: each accepted transfer writes the expected outputs for the next three cycles
   // into a small schedule; unscheduled cycles are idle (ready, OKAY, no select).
   typedef struct packed {
      logic       valid;
      logic [3:0] psel;
      logic       pen;
      logic       hrdy;
      logic       hresp;
      logic       capw;
      logic       capr;
   } slot_t;

   slot_t       sched [8];
   int unsigned cyc = 0;
   logic [11:0] exp_paddr;
   logic        exp_pwrite;
   logic [31:0] exp_pwdata;
   logic [31:0] exp_hrdata;

   task automatic setSlot(input int unsigned c, input logic [3:0] psel, input logic pen,
                          input logic hrdy, input logic hresp, input logic capw, input logic capr);
      sched[c % 8] = '{1'b1, psel, pen, hrdy, hresp, capw, capr};
   endtask

   always @(negedge HCLK) begin : model
      slot_t       e;
      int          idx;
      logic [3:0]  oh;
      if (!nRESET) begin
         for (int i = 0; i < 8; i++) sched[i] = '0;
         exp_paddr  = '0;
         exp_pwrite = 1'b0;
         exp_pwdata = '0;
         exp_hrdata = '0;
      end else begin
         e = sched[cyc % 8];
         if (!e.valid) e = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
         checkOutput("model HREADYOUT", 32'(HREADYOUT), 32'(e.hrdy));
         checkOutput("model HRESP", 32'(HRESP), 32'(e.hresp));
         checkOutput("model PSEL", 32'(PSEL), 32'(e.psel));
         checkOutput("model PENABLE", 32'(PENABLE), 32'(e.pen));
         checkOutput("model PWRITE", 32'(PWRITE), 32'(exp_pwrite));
         checkOutput("model PADDR", 32'(PADDR), 32'(exp_paddr));
         checkOutput("model PWDATA", PWDATA, exp_pwdata);
         checkOutput("model HRDATA", HRDATA, exp_hrdata);
         sched[cyc % 8] = '0;
         if (e.capw) exp_pwdata = HWDATA;
         if (e.capr) exp_hrdata = PRDATA;
         if (e.hrdy && HSEL && HREADY && HTRANS[1]) begin
            idx        = int'(HADDR[15:12]);
            exp_paddr  = HADDR[11:0];
            exp_pwrite = HWRITE;
            if (idx >= NS) begin
               setSlot(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
               setSlot(cyc + 2, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            end else begin
               oh = 4'(1 << idx);
               if (HWRITE) begin
                  setSlot(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                  setSlot(cyc + 2, oh,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                  setSlot(cyc + 3, oh,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
               end else begin
                  setSlot(cyc + 1, oh,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                  setSlot(cyc + 2, oh,      1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                  setSlot(cyc + 3, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
               end
            end
         end
      end
      cyc++;
   end

   initial begin
      nRESET = 1'b0;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
      PRDATA = '0; hready_block = 1'b0;
      #12;
      checkOutput("reset HREADYOUT", 32'(HREADYOUT), 32'd1);
      checkOutput("reset HRESP", 32'(HRESP), 32'd0);
      checkOutput("reset PSEL", 32'(PSEL), 32'd0);
      checkOutput("reset PENABLE", 32'(PENABLE), 32'd0);
      checkOutput("reset PWRITE", 32'(PWRITE), 32'd0);
      checkOutput("reset PADDR", 32'(PADDR), 32'd0);
      checkOutput("reset PWDATA", PWDATA, 32'd0);
      checkOutput("reset HRDATA", HRDATA, 32'd0);
      #10;
      nRESET = 1'b1;

      // Read from slave 1
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_1010, 32'h0, 32'h0000_0055, 1'b0);
      idleCycle(32'h0000_0055);
      @(negedge HCLK);
      checkOutput("rd T1 PSEL", 32'(PSEL), 32'h2);
      checkOutput("rd T1 PADDR", 32'(PADDR), 32'h010);
      checkOutput("rd T1 PENABLE", 32'(PENABLE), 32'd0);
      checkOutput("rd T1 HREADYOUT", 32'(HREADYOUT), 32'd0);
      idleCycle(32'h0000_0055);
      @(negedge HCLK);
      checkOutput("rd T2 PSEL", 32'(PSEL), 32'h2);
      checkOutput("rd T2 PENABLE", 32'(PENABLE), 32'd1);
      checkOutput("rd T2 HREADYOUT", 32'(HREADYOUT), 32'd0);
      idleCycle(32'hDEAD_BEEF);
      @(negedge HCLK);
      checkOutput("rd T3 HRDATA", HRDATA, 32'h0000_0055);
      checkOutput("rd T3 HREADYOUT", 32'(HREADYOUT), 32'd1);
      checkOutput("rd T3 PSEL", 32'(PSEL), 32'd0);

      // Write to slave 0, then a read accepted during the write's ENABLE
      applyStimulus(1'b1, 2'b10, 1'b1, 32'h0000_0008, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_A05F, 32'h0, 1'b0);
      @(negedge HCLK);
      checkOutput("wr T1 HREADYOUT", 32'(HREADYOUT), 32'd0);
      checkOutput("wr T1 PSEL", 32'(PSEL), 32'd0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h1111_2222, 32'h0, 1'b0);
      @(negedge HCLK);
      checkOutput("wr T2 PSEL", 32'(PSEL), 32'h1);
      checkOutput("wr T2 PADDR", 32'(PADDR), 32'h008);
      checkOutput("wr T2 PWRITE", 32'(PWRITE), 32'd1);
      checkOutput("wr T2 PWDATA", PWDATA, 32'h0000_A05F);
      checkOutput("wr T2 PENABLE", 32'(PENABLE), 32'd0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_2004, 32'h0, 32'h1234_5678, 1'b0);
      @(negedge HCLK);
      checkOutput("wr T3 PENABLE", 32'(PENABLE), 32'd1);
      checkOutput("wr T3 HREADYOUT", 32'(HREADYOUT), 32'd1);
      checkOutput("wr T3 HRDATA kept", HRDATA, 32'h0000_0055);
      idleCycle(32'h1234_5678);
      @(negedge HCLK);
      checkOutput("b2b SETUP PSEL", 32'(PSEL), 32'h4);
      checkOutput("b2b SETUP PWRITE", 32'(PWRITE), 32'd0);
      checkOutput("b2b SETUP PADDR", 32'(PADDR), 32'h004);
      checkOutput("b2b SETUP PENABLE", 32'(PENABLE), 32'd0);
      idleCycle(32'h1234_5678);
      idleCycle(32'h0);
      @(negedge HCLK);
      checkOutput("b2b HRDATA", HRDATA, 32'h1234_5678);

      // Unmapped slave 5, followed by an OKAY read accepted in ERR2
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 1'b0);
      idleCycle(32'h0);
      @(negedge HCLK);
      checkOutput("err1 PSEL", 32'(PSEL), 32'd0);
      checkOutput("err1 HREADYOUT", 32'(HREADYOUT), 32'd0);
      checkOutput("err1 HRESP", 32'(HRESP), 32'd1);
      checkOutput("err1 HRDATA kept", HRDATA, 32'h1234_5678);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checkOutput("err2 HREADYOUT", 32'(HREADYOUT), 32'd1);
      checkOutput("err2 HRESP", 32'(HRESP), 32'd1);
      idleCycle(32'h0);
      @(negedge HCLK);
      checkOutput("after err HRESP", 32'(HRESP), 32'd0);
      checkOutput("after err PSEL", 32'(PSEL), 32'h8);
      idleCycle(32'h0);
      idleCycle(32'h0);

      // Transfers that must be ignored
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b1, 32'h0000_1000, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b1, 32'h0000_2000, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         idleCycle(32'h0);
         @(negedge HCLK);
         checkOutput("ignored PSEL", 32'(PSEL), 32'd0);
         checkOutput("ignored HREADYOUT", 32'(HREADYOUT), 32'd1);
         checkOutput("ignored HRESP", 32'(HRESP), 32'd0);
      end

      // Reset during the ENABLE cycle of a write
      applyStimulus(1'b1, 2'b10, 1'b1, 32'h0000_1004, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'hCAFE_0001, 32'h0, 1'b0);
      idleCycle(32'h0);
      idleCycle(32'h0);
      #1;
      checkOutput("pre-reset PENABLE", 32'(PENABLE), 32'd1);
      nRESET = 1'b0;
      #1;
      checkOutput("async rst PSEL", 32'(PSEL), 32'd0);
      checkOutput("async rst PENABLE", 32'(PENABLE), 32'd0);
      checkOutput("async rst HREADYOUT", 32'(HREADYOUT), 32'd1);
      @(negedge HCLK);
      #2;
      nRESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idleCycle(32'h0);
         @(negedge HCLK);
         checkOutput("post-reset PSEL", 32'(PSEL), 32'd0);
         checkOutput("post-reset PENABLE", 32'(PENABLE), 32'd0);
      end

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 7) != 0),
                       2'($urandom_range(0, 3) | ($urandom_range(0, 1) << 1)),
                       1'($urandom_range(0, 1)),
                       {16'($urandom), 4'($urandom_range(0, 5)), 12'($urandom)},
                       32'($urandom), 32'($urandom),
                       1'($urandom_range(0, 7) == 0));
      end
      idleCycle(32'h0);
      repeat (5) @(posedge HCLK);
      @(negedge HCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
